// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the seq_divider block.
//   div_state_e        - controller states (IDLE, CALC, DONE)
//   DIV_WIDTH_DEF      - default operand width
//   div_zero_quotient  - all-ones quotient returned for a zero divisor
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEF = 8;

  // All-ones pattern of the given width (width 1..32), right-aligned.
  function automatic logic [31:0] div_zero_quotient(input int width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle for seq_divider.
//   start, dividend, divisor          - request side (driven by master)
//   busy, done, quotient, remainder,
//   div_by_zero, check_err            - status/result side (driven by slave)
// Modports: master (requester), slave (the divider).
interface seq_divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             check_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, check_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, check_err
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_in  - current partial remainder (always < divisor)
//   din     - next dividend bit, MSB first
//   divisor - denominator
//   rem_out - partial remainder after this step
//   q_bit   - quotient bit produced by this step
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  // The shifted value needs one extra bit; the subtracted result is always
  // below the divisor, so a WIDTH-bit wrapping subtract gives it exactly.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {rem_in, din};
    diff    = shifted[WIDTH-1:0] - divisor;
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring unsigned divider.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - seq_divider_if slave: start/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero/check_err out
// Optional macro SEQ_DIVIDER_SELFCHECK_EN: reconstructs each result as
// quotient*divisor+remainder and raises a sticky check_err on mismatch.
// Timing: start at edge k -> CALC for WIDTH cycles -> DONE state, whose
// edge registers the results and raises done (edge k+WIDTH+1). A zero
// divisor goes straight to DONE (done after edge k+1).
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int               CW    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(div_zero_quotient(WIDTH));

  div_state_e       state_reg;
  logic [CW-1:0]    cnt_reg;
  // dvd_reg shifts the dividend out at the top and the quotient in at the
  // bottom, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             dz_pend_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dz_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rmd_reg;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic             accept;

  // start is honoured only when not iterating (IDLE or DONE).
  assign accept = (state_reg != CALC) && bus.start;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .din     (dvd_reg[WIDTH-1]),
    .divisor (dvs_reg),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      dz_pend_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
      quo_reg     <= '0;
      rmd_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        CALC: begin
          dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE share start handling so DONE can chain operations.
          if (state_reg == DONE) begin
            done_reg <= 1'b1;
            quo_reg  <= dvd_reg;
            rmd_reg  <= rem_reg;
            dz_reg   <= dz_pend_reg;
          end
          state_reg <= IDLE;
          if (accept) begin
            if (bus.divisor == '0) begin
              dvd_reg     <= DBZ_Q;
              rem_reg     <= bus.dividend;
              dz_pend_reg <= 1'b1;
              state_reg   <= DONE;
            end else begin
              dvd_reg     <= bus.dividend;
              dvs_reg     <= bus.divisor;
              rem_reg     <= '0;
              cnt_reg     <= CW'(WIDTH - 1);
              dz_pend_reg <= 1'b0;
              busy_reg    <= 1'b1;
              state_reg   <= CALC;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quo_reg;
  assign bus.remainder   = rmd_reg;
  assign bus.div_by_zero = dz_reg;

`ifdef SEQ_DIVIDER_SELFCHECK_EN
  localparam int DW = 2 * WIDTH;

  logic [WIDTH-1:0] orig_reg;
  logic             chk_reg;
  logic [DW-1:0]    recon;
  logic             mismatch;

  // Evaluated on the held result while in DONE, before it is published.
  always_comb begin
    recon    = DW'(dvd_reg) * DW'(dvs_reg) + DW'(rem_reg);
    mismatch = (recon != DW'(orig_reg)) || (rem_reg >= dvs_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orig_reg <= '0;
      chk_reg  <= 1'b0;
    end else begin
      if (accept && (bus.divisor != '0)) begin
        orig_reg <= bus.dividend;
      end
      if ((state_reg == DONE) && !dz_pend_reg && mismatch) begin
        chk_reg <= 1'b1;
      end
    end
  end

  assign bus.check_err = chk_reg;
`else
  assign bus.check_err = 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=8).
// Expected results come from a table of known answers and from a plain
// arithmetic model (a/b, a%b); a negedge monitor matches every done pulse
// against a queue of expected results, including latency in clock edges.
module tb_seq_divider;
  import divider_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           st;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dz = 1'b0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.st = 0;
    if (b == 0) begin
      e.q   = W'((1 << W) - 1);
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dz  = 1'b0;
      e.lat = W + 1;
    end
    return e;
  endfunction

  // Result monitor: every done must match the oldest outstanding request;
  // between dones the published results must not move.
  always @(negedge clk) begin
    if (rst) begin
      last_q  = '0;
      last_r  = '0;
      last_dz = 1'b0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient", bus.quotient, mon_e.q);
        chk("remainder", bus.remainder, mon_e.r);
        chk("div_by_zero", bus.div_by_zero, mon_e.dz);
        chk("latency", cyc - mon_e.st, mon_e.lat);
        chk("check_err", bus.check_err, 0);
        $display("op done: q=%0d r=%0d dz=%0d latency=%0d", bus.quotient,
                 bus.remainder, bus.div_by_zero, cyc - mon_e.st);
      end
      last_q  = bus.quotient;
      last_r  = bus.remainder;
      last_dz = bus.div_by_zero;
    end else begin
      chk("hold_quotient", bus.quotient, last_q);
      chk("hold_remainder", bus.remainder, last_r);
      chk("hold_div_by_zero", bus.div_by_zero, last_dz);
    end
  end

  // Called at a negedge; returns at the negedge just before the edge where
  // the DUT sits in DONE, so a following call starts back-to-back.
  // noise: 0 quiet, 1 random start/operand noise during CALC,
  //        2 start pulse with 50/3 on the third CALC cycle plus operand toggles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input int noise, output int nbusy);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e.st = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = 0;
    for (int j = 0; j < e.lat - 1; j++) begin
      nbusy += int'(bus.busy);
      if (noise == 1) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
      end else if (noise == 2) begin
        bus.start    = (j == 2);
        bus.dividend = (j == 2) ? W'(50) : W'($urandom);
        bus.divisor  = (j == 2) ? W'(3)  : W'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  vec_t vecs[9];
  exp_t e;
  int   nb;

  initial begin
    vecs[0] = '{a: 100, b: 7,   q: 14,  r: 2,  dz: 0};
    vecs[1] = '{a: 255, b: 1,   q: 255, r: 0,  dz: 0};
    vecs[2] = '{a: 3,   b: 200, q: 0,   r: 3,  dz: 0};
    vecs[3] = '{a: 0,   b: 9,   q: 0,   r: 0,  dz: 0};
    vecs[4] = '{a: 5,   b: 0,   q: 255, r: 5,  dz: 1};
    vecs[5] = '{a: 200, b: 13,  q: 15,  r: 5,  dz: 0};
    vecs[6] = '{a: 0,   b: 0,   q: 255, r: 0,  dz: 1};
    vecs[7] = '{a: 255, b: 255, q: 1,   r: 0,  dz: 0};
    vecs[8] = '{a: 254, b: 16,  q: 15,  r: 14, dz: 0};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_quotient", bus.quotient, 0);
    chk("reset_remainder", bus.remainder, 0);
    chk("reset_div_by_zero", bus.div_by_zero, 0);
    chk("reset_check_err", bus.check_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 100/7 alone: busy for exactly W cycles, low in the DONE cycle.
    e = model(8'd100, 8'd7);
    run_op(8'd100, 8'd7, e, 0, nb);
    chk("busy_cycles", nb, W);
    chk("busy_in_done", bus.busy, 0);
    repeat (3) @(negedge clk);

    // Known-answer table, issued back-to-back.
    for (int i = 0; i < 9; i++) begin
      e.q   = vecs[i].q;
      e.r   = vecs[i].r;
      e.dz  = vecs[i].dz;
      e.lat = vecs[i].dz ? 1 : W + 1;
      run_op(vecs[i].a, vecs[i].b, e, 0, nb);
    end
    repeat (3) @(negedge clk);

    // Start and operand changes during CALC must be ignored.
    e = model(8'd100, 8'd7);
    run_op(8'd100, 8'd7, e, 2, nb);
    repeat (3) @(negedge clk);

    // Asynchronous reset on CALC cycle 4 of an in-flight operation.
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_div_by_zero", bus.div_by_zero, 0);
    chk("abort_check_err", bus.check_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    e = model(8'd200, 8'd13);
    run_op(8'd200, 8'd13, e, 0, nb);
    repeat (3) @(negedge clk);

    // Randomised operands against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      e = model(a, b);
      run_op(a, b, e, 1, nb);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    chk("pending_results", exp_q.size(), 0);
    chk("final_check_err", bus.check_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
